// File: rtl/dac_playback_ctrl_pkg.sv
// Shared types for the DAC playback path: sample word layout, idle code, FSM states.
package dac_playback_ctrl_pkg;

    localparam logic [13:0] DAC_IDLE_CODE = 14'h2000;

    typedef struct packed {
        logic [1:0]  pad1;
        logic [13:0] ch1;
        logic [1:0]  pad0;
        logic [13:0] ch0;
    } dac_sample_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        RUN
    } dacpb_state_e;

endpackage

// File: rtl/dac_playback_ctrl_if.sv
// CSR, DPRAM read-port and DAC signals of the playback controller.
// master = controller side, slave = CSR/memory/DAC environment.
interface dac_playback_ctrl_if #(
    parameter int ADDR_WIDTH = 11,
    parameter int DAC_W      = 14,
    parameter int RATE_W     = 16
);
    logic                  csr_start_i;
    logic                  csr_stop_i;
    logic                  csr_loop_i;
    logic [ADDR_WIDTH:0]   csr_len_i;
    logic [RATE_W-1:0]     csr_div_i;
    logic                  csr_busy_o;
    logic                  csr_done_o;
    logic                  mem_rd_en_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [31:0]           mem_data_i;
    logic [DAC_W-1:0]      dac_ch0_o;
    logic [DAC_W-1:0]      dac_ch1_o;
    logic                  dac_vld_o;

    modport master (
        input  csr_start_i, csr_stop_i, csr_loop_i, csr_len_i, csr_div_i, mem_data_i,
        output csr_busy_o, csr_done_o, mem_rd_en_o, mem_addr_o, dac_ch0_o, dac_ch1_o, dac_vld_o
    );

    modport slave (
        output csr_start_i, csr_stop_i, csr_loop_i, csr_len_i, csr_div_i, mem_data_i,
        input  csr_busy_o, csr_done_o, mem_rd_en_o, mem_addr_o, dac_ch0_o, dac_ch1_o, dac_vld_o
    );
endinterface

// File: rtl/dac_playback_ctrl_rate_gen.sv
// Sample-period down-counter: tick when count hits zero, then reload; held at zero
// while disabled so the first enabled cycle ticks immediately.
module dac_rate_gen #(
    parameter int RATE_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [RATE_W-1:0] reload,
    output logic              tick
);
    logic [RATE_W-1:0] cnt_q;

    assign tick = en && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n || !en) cnt_q <= '0;
        else if (tick)     cnt_q <= reload;
        else               cnt_q <= cnt_q - 1'b1;
    end
endmodule

// File: rtl/dac_playback_ctrl.sv
// DAC waveform playback: streams DPRAM samples to the dual DAC at a programmable rate.
// Build option: DAC_PLAYBACK_SIGNED_EN converts two's-complement samples to offset binary.
module dac_playback_ctrl
    import dac_playback_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DAC_W      = 14,
    parameter int RATE_W     = 16
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    dac_playback_ctrl_if.master bus
);
    localparam logic [ADDR_WIDTH:0] LEN_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam int NUM_CH = 2;

    dacpb_state_e state_q, state_d;
    logic                          start_q, start_edge;
    logic [ADDR_WIDTH:0]           len_q, len_clamp;
    logic [RATE_W-1:0]             div_q, reload;
    logic                          loop_q, last_q, busy_q, done_q, vld_q, pf_load_q;
    dac_sample_t                   pf_q;
    logic [ADDR_WIDTH-1:0]         pf_idx_q, next_idx, rd_addr;
    logic                          is_last, tick, rd_en;
    logic                          enter, present, finish;
    logic [NUM_CH-1:0][DAC_W-1:0]  raw, conv, code_q;

    assign start_edge = bus.csr_start_i & ~start_q;
    assign len_clamp  = (bus.csr_len_i > LEN_MAX) ? LEN_MAX : bus.csr_len_i;
    assign reload     = (div_q == '0) ? RATE_W'(1) : div_q;
    // pf_idx_q is the index of the sample waiting in the prefetch register
    assign is_last    = ({1'b0, pf_idx_q} == (len_q - 1'b1));
    assign next_idx   = is_last ? '0 : pf_idx_q + 1'b1;

    dac_rate_gen #(.RATE_W(RATE_W)) u_rate (
        .clk    (sys_clk),
        .rst_n  (sys_rst_n),
        .en     (state_q == RUN),
        .reload (reload),
        .tick   (tick)
    );

    always_comb begin
        state_d = state_q;
        rd_en   = 1'b0;
        rd_addr = '0;
        enter   = 1'b0;
        present = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: if (start_edge && !bus.csr_stop_i) begin
                enter   = 1'b1;
                rd_en   = (len_clamp != '0);
                state_d = PRIME;
            end
            PRIME: if (bus.csr_stop_i || len_q == '0) begin
                finish  = 1'b1;
                state_d = IDLE;
            end else begin
                state_d = RUN;
            end
            RUN: if (bus.csr_stop_i) begin
                finish  = 1'b1;
                state_d = IDLE;
            end else if (tick) begin
                if (last_q) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end else begin
                    present = 1'b1;
                    rd_en   = loop_q || !is_last;
                    rd_addr = next_idx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign raw[0] = pf_q.ch0;
    assign raw[1] = pf_q.ch1;
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
`ifdef DAC_PLAYBACK_SIGNED_EN
        assign conv[c] = {~raw[c][DAC_W-1], raw[c][DAC_W-2:0]};
`else
        assign conv[c] = raw[c];
`endif
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q   <= IDLE;
            start_q   <= 1'b0;
            len_q     <= '0;
            div_q     <= '0;
            loop_q    <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            vld_q     <= 1'b0;
            pf_load_q <= 1'b0;
            pf_q      <= '0;
            pf_idx_q  <= '0;
            code_q    <= {NUM_CH{DAC_W'(DAC_IDLE_CODE)}};
        end else begin
            state_q   <= state_d;
            start_q   <= bus.csr_start_i;
            vld_q     <= present;
            pf_load_q <= rd_en;
            if (pf_load_q) pf_q <= dac_sample_t'(bus.mem_data_i);
            if (enter) begin
                len_q    <= len_clamp;
                div_q    <= bus.csr_div_i;
                loop_q   <= bus.csr_loop_i;
                pf_idx_q <= '0;
                last_q   <= 1'b0;
                busy_q   <= 1'b1;
                done_q   <= 1'b0;
            end
            if (present) begin
                code_q   <= conv;
                pf_idx_q <= next_idx;
                last_q   <= is_last && !loop_q;
            end
            if (finish) begin
                code_q <= {NUM_CH{DAC_W'(DAC_IDLE_CODE)}};
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end
        end
    end

    logic unused_pad;
    assign unused_pad = &{1'b0, pf_q.pad0, pf_q.pad1};

    assign bus.csr_busy_o  = busy_q;
    assign bus.csr_done_o  = done_q;
    assign bus.mem_rd_en_o = rd_en & sys_rst_n;
    assign bus.mem_addr_o  = rd_addr;
    assign bus.dac_ch0_o   = code_q[0];
    assign bus.dac_ch1_o   = code_q[1];
    assign bus.dac_vld_o   = vld_q;
endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Directed bench for dac_playback_ctrl with a DPRAM model and a sample scoreboard.
module tb_dac_playback_ctrl;
    typedef struct { logic [13:0] ch0; logic [13:0] ch1; } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dac_playback_ctrl_if bus ();
    dac_playback_ctrl dut (.sys_clk(clk), .sys_rst_n(rst_n), .bus(bus));

    logic [31:0] mem [0:2047];
    exp_t sbq [$];
    int n_cmp = 0, n_err = 0;
    int cyc = 0, rd_cnt = 0, vld_n = 0;
    int last_vld = -1, first_vld = -1, exp_period = 0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.mem_rd_en_o) begin
            rd_cnt <= rd_cnt + 1;
            bus.mem_data_i <= mem[bus.mem_addr_o];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [13:0] conv(input logic [13:0] r);
`ifdef DAC_PLAYBACK_SIGNED_EN
        return r ^ 14'h2000;
`else
        return r;
`endif
    endfunction

    function automatic logic [31:0] pat(input int i);
        return {2'b00, 14'(i * 7 + 'h100), 2'b00, 14'(i + 1)};
    endfunction

    always @(negedge clk) begin
        if (bus.dac_vld_o === 1'b1) begin
            if (sbq.size() == 0) chk("vld_unexpected", 32'd1, 32'd0);
            else begin
                exp_t e;
                e = sbq.pop_front();
                chk("ch0", 32'(bus.dac_ch0_o), 32'(e.ch0));
                chk("ch1", 32'(bus.dac_ch1_o), 32'(e.ch1));
                if (last_vld >= 0) chk("period", 32'(cyc - last_vld), 32'(exp_period));
            end
            if (last_vld < 0) first_vld = cyc;
            last_vld = cyc;
            vld_n++;
        end
    end

    task automatic push_seq(input int len, input int n);
        exp_t e;
        int idx;
        for (int i = 0; i < n; i++) begin
            idx = i % len;
            e.ch0 = conv(mem[idx][13:0]);
            e.ch1 = conv(mem[idx][29:16]);
            sbq.push_back(e);
        end
    endtask

    task automatic setup(input int len, input int div, input logic lp);
        bus.csr_len_i  = 12'(len);
        bus.csr_div_i  = 16'(div);
        bus.csr_loop_i = lp;
        exp_period = ((div < 1) ? 1 : div) + 1;
        last_vld   = -1;
        first_vld  = -1;
    endtask

    task automatic pulse_start();
        bus.csr_start_i = 1'b1;
        @(negedge clk);
        bus.csr_start_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while (bus.csr_busy_o === 1'b1 && n < budget) begin @(negedge clk); n++; end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic wait_vld(input string tag, input int target, input int budget);
        int n = 0;
        while (vld_n < target && n < budget) begin @(negedge clk); n++; end
        chk(tag, 32'(n < budget), 32'd1);
    endtask

    task automatic chk_idle_outputs(input string tag, input logic exp_done);
        chk({tag, "_busy"}, 32'(bus.csr_busy_o), 32'd0);
        chk({tag, "_done"}, 32'(bus.csr_done_o), 32'(exp_done));
        chk({tag, "_vld"},  32'(bus.dac_vld_o),  32'd0);
        chk({tag, "_ch0"},  32'(bus.dac_ch0_o),  32'h2000);
        chk({tag, "_ch1"},  32'(bus.dac_ch1_o),  32'h2000);
        chk({tag, "_rden"}, 32'(bus.mem_rd_en_o), 32'd0);
        chk({tag, "_addr"}, 32'(bus.mem_addr_o), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, rd0, v0;
        for (int i = 0; i < 2048; i++) mem[i] = pat(i);
        bus.csr_start_i = 1'b0;
        bus.csr_stop_i  = 1'b0;
        setup(0, 0, 1'b0);
        repeat (3) @(negedge clk);
        chk_idle_outputs("reset", 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // one-shot, len 4, period 4
        setup(4, 3, 1'b0);
        push_seq(4, 4);
        rd0 = rd_cnt; v0 = vld_n;
        pulse_start();
        c0 = cyc;
        chk("t1_busy_set", 32'(bus.csr_busy_o), 32'd1);
        chk("t1_done_clr", 32'(bus.csr_done_o), 32'd0);
        wait_idle("t1_timeout", 100);
        chk("t1_first_vld", 32'(first_vld - c0), 32'd2);
        chk("t1_vld_count", 32'(vld_n - v0), 32'd4);
        chk("t1_reads", 32'(rd_cnt - rd0), 32'd4);
        chk("t1_sb_empty", 32'(sbq.size()), 32'd0);
        chk_idle_outputs("t1_end", 1'b1);

        // loop, len 3, period 2, stop after three passes
        setup(3, 0, 1'b1);
        push_seq(3, 9);
        v0 = vld_n;
        pulse_start();
        wait_vld("t2_timeout", v0 + 9, 100);
        bus.csr_stop_i = 1'b1;
        @(negedge clk);
        bus.csr_stop_i = 1'b0;
        chk_idle_outputs("t2_stop", 1'b1);
        repeat (6) @(negedge clk);
        chk("t2_vld_count", 32'(vld_n - v0), 32'd9);
        chk("t2_sb_empty", 32'(sbq.size()), 32'd0);

        // len 0: no reads, done cleared for one cycle
        setup(0, 5, 1'b0);
        rd0 = rd_cnt;
        for (int k = 0; k < 2; k++) begin
            pulse_start();
            chk("t3_done_clr", 32'(bus.csr_done_o), 32'd0);
            @(negedge clk);
            chk("t3_done_set", 32'(bus.csr_done_o), 32'd1);
            chk("t3_busy", 32'(bus.csr_busy_o), 32'd0);
            repeat (2) @(negedge clk);
        end
        chk("t3_reads", 32'(rd_cnt - rd0), 32'd0);

        // start edge and parameter changes while running are ignored
        setup(4, 2, 1'b0);
        push_seq(4, 4);
        v0 = vld_n;
        pulse_start();
        wait_vld("t4_wait", v0 + 2, 100);
        bus.csr_len_i = 12'd2; bus.csr_div_i = 16'd7; bus.csr_loop_i = 1'b1;
        pulse_start();
        wait_idle("t4_timeout", 100);
        chk("t4_vld_count", 32'(vld_n - v0), 32'd4);
        chk("t4_sb_empty", 32'(sbq.size()), 32'd0);
        chk("t4_done", 32'(bus.csr_done_o), 32'd1);
        // start and stop together: no playback
        setup(3, 1, 1'b0);
        rd0 = rd_cnt; v0 = vld_n;
        bus.csr_start_i = 1'b1; bus.csr_stop_i = 1'b1;
        @(negedge clk);
        bus.csr_start_i = 1'b0; bus.csr_stop_i = 1'b0;
        repeat (6) @(negedge clk);
        chk("t4_ss_busy", 32'(bus.csr_busy_o), 32'd0);
        chk("t4_ss_done", 32'(bus.csr_done_o), 32'd1);
        chk("t4_ss_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("t4_ss_vld", 32'(vld_n - v0), 32'd0);

        // reset mid-loop
        setup(3, 1, 1'b1);
        push_seq(3, 6);
        v0 = vld_n;
        pulse_start();
        wait_vld("t5_wait", v0 + 4, 100);
        rst_n = 1'b0;
        rd0 = rd_cnt;
        @(negedge clk);
        chk_idle_outputs("t5_rst", 1'b0);
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("t5_reads", 32'(rd_cnt - rd0), 32'd0);
        chk("t5_busy", 32'(bus.csr_busy_o), 32'd0);

        // oversize length clamps to full memory
        setup(12'hFFF, 1, 1'b0);
        push_seq(2048, 2048);
        rd0 = rd_cnt; v0 = vld_n;
        pulse_start();
        wait_idle("t_clamp_timeout", 6000);
        chk("t_clamp_vld", 32'(vld_n - v0), 32'd2048);
        chk("t_clamp_reads", 32'(rd_cnt - rd0), 32'd2048);
        chk("t_clamp_sb", 32'(sbq.size()), 32'd0);

        // sample format extremes
        mem[0] = {2'b00, 14'h1FFF, 2'b00, 14'h3FFF};
        setup(1, 1, 1'b0);
        push_seq(1, 1);
        v0 = vld_n;
        pulse_start();
        wait_idle("t6_timeout", 50);
        chk("t6_vld", 32'(vld_n - v0), 32'd1);
        chk("t6_sb", 32'(sbq.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
